// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/grant/rvalid bus between the fetch stage and memory.
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            instr_req_o;
    logic [XLEN-1:0] instr_addr_o;
    logic            instr_gnt_i;
    logic            instr_rvalid_i;
    logic [XLEN-1:0] instr_rdata_i;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage. It owns the fetch PC, keeps one memory request in flight,
// buffers responses in a prefetch FIFO and presents instruction/PC/PC+4 to decode.
// Build option: define IF_BYPASS_EN to forward a response straight into decode when the FIFO is empty.
module if_stage #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    if_stage_if.master  mem,
    input  logic        stall_i,
    input  logic        brj_i,
    input  logic [31:0] brj_pc_i,
    output logic [31:0] d_instruction_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_pc4_o
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {ST_REQ, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              discard_q, discard_d;
    logic              req_q, req_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   instr_d, pc_d, pc4_d;
    logic [XLEN-1:0]   fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0]   fifo_instr [FIFO_DEPTH];

    logic              redirect, fifo_empty, rsp_ok, bypass, push, pop;
    logic [XLEN-1:0]   target;
    logic              brj_pc_unused;

    assign mem.instr_req_o  = req_q;
    assign mem.instr_addr_o = fetch_pc_q;

    // A stalled decode cannot take a redirect; low address bits are dropped.
    assign redirect      = brj_i & ~stall_i;
    assign target        = {brj_pc_i[XLEN-1:2], 2'b00};
    assign brj_pc_unused = ^brj_pc_i[1:0];
    assign fifo_empty    = (count_q == '0);

    // A response is kept only in WAIT, when not marked stale and not flushed by a redirect now.
    assign rsp_ok = (state_q == ST_WAIT) & mem.instr_rvalid_i & ~discard_q & ~redirect;
`ifdef IF_BYPASS_EN
    assign bypass = rsp_ok & fifo_empty & ~stall_i;
`else
    assign bypass = 1'b0;
`endif
    assign push = rsp_ok & ~bypass;
    assign pop  = ~stall_i & ~redirect & ~fifo_empty;

    // Next-state, fetch PC, FIFO bookkeeping and decode register selection.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_pc_d   = out_pc_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instr_d    = d_instruction_o;
        pc_d       = d_pc_o;
        pc4_d      = d_pc4_o;

        unique case (state_q)
            ST_REQ: begin
                if (req_q && mem.instr_gnt_i) begin
                    out_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.instr_rvalid_i) begin
                    discard_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect) begin
            fetch_pc_d = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A request still in flight after this edge must have its response dropped.
            // If its response arrives right now it is simply not kept and fetch resumes.
            if ((state_q == ST_WAIT && !mem.instr_rvalid_i) ||
                (state_q == ST_REQ && req_q && mem.instr_gnt_i)) begin
                discard_d = 1'b1;
                state_d   = ST_WAIT;
            end
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        if (stall_i) begin
            instr_d = d_instruction_o;
        end else if (brj_i) begin
            instr_d = NOP_INSTR;
        end else if (!fifo_empty) begin
            instr_d = fifo_instr[rd_ptr_q];
            pc_d    = fifo_pc[rd_ptr_q];
            pc4_d   = fifo_pc[rd_ptr_q] + 32'd4;
        end else if (bypass) begin
            instr_d = mem.instr_rdata_i;
            pc_d    = out_pc_q;
            pc4_d   = out_pc_q + 32'd4;
        end else begin
            instr_d = NOP_INSTR;
        end
    end

    // Only request when nothing is outstanding and the FIFO will have room for the answer.
    assign req_d = (state_d == ST_REQ) && (count_d < CNT_W'(FIFO_DEPTH));

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_REQ;
            fetch_pc_q      <= BOOT_ADDR;
            out_pc_q        <= BOOT_ADDR;
            discard_q       <= 1'b0;
            req_q           <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            d_instruction_o <= NOP_INSTR;
            d_pc_o          <= '0;
            d_pc4_o         <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            out_pc_q        <= out_pc_d;
            discard_q       <= discard_d;
            req_q           <= req_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            d_instruction_o <= instr_d;
            d_pc_o          <= pc_d;
            d_pc4_o         <= pc4_d;
        end
    end

    // Prefetch storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= out_pc_q;
            fifo_instr[wr_ptr_q] <= mem.instr_rdata_i;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus a randomized run checked against a program-order model:
// decode must see BOOT_ADDR, +4, +4, ... restarting at each accepted redirect target.
module tb_if_stage;
    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        stall  = 1'b0;
    logic        brj    = 1'b0;
    logic [31:0] brj_pc = '0;
    logic [31:0] d_instr, d_pc, d_pc4;

    int n_cmp = 0;
    int n_bad = 0;

    int          gnt_pct = 100, lat_min = 1, lat_max = 1;
    bit          keep_pend = 1'b0, pend = 1'b0, stale_seen = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    logic [31:0] gnt_log[$];

    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem             (bus),
        .stall_i         (stall),
        .brj_i           (brj),
        .brj_pc_i        (brj_pc),
        .d_instruction_o (d_instr),
        .d_pc_o          (d_pc),
        .d_pc4_o         (d_pc4)
    );

    // Memory contents: never equal to the NOP encoding, so a non-NOP in decode is a real fetch.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a ^ 32'h1234_5670) | 32'h8000_0000;
    endfunction

    // Memory model: one transaction at a time, rvalid lat_min..lat_max cycles after gnt.
    initial begin
        bus.instr_gnt_i    = 1'b0;
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = '0;
        forever begin
            @(negedge clk);
            bus.instr_gnt_i    = 1'b0;
            bus.instr_rvalid_i = 1'b0;
            if (!rst_n && !keep_pend) pend = 1'b0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    bus.instr_rvalid_i = 1'b1;
                    bus.instr_rdata_i  = word_at(pend_addr);
                    pend = 1'b0;
                    if (keep_pend && rst_n) stale_seen = 1'b1;
                end else begin
                    pend_cnt--;
                end
            end else if (rst_n && bus.instr_req_o && (int'($urandom_range(99)) < gnt_pct)) begin
                bus.instr_gnt_i = 1'b1;
                pend      = 1'b1;
                pend_addr = bus.instr_addr_o;
                pend_cnt  = int'($urandom_range(lat_max, lat_min));
                gnt_log.push_back(bus.instr_addr_o);
            end
        end
    end

    task automatic do_reset();
        stall = 1'b0; brj = 1'b0; brj_pc = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for the next decoded (non-NOP) instruction; ok=0 if none within the budget.
    task automatic next_decoded(output bit ok, output logic [31:0] i, output logic [31:0] p,
                                output logic [31:0] p4);
        ok = 1'b0; i = '0; p = '0; p4 = '0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(posedge clk); #1;
            if (d_instr != NOP) begin
                ok = 1'b1; i = d_instr; p = d_pc; p4 = d_pc4;
            end
        end
    endtask

    task automatic test_reset();
        int g0;
        rst_n = 1'b0; stall = 1'b0; brj = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.instr_req_o, bus.instr_addr_o, d_instr, d_pc, d_pc4} !== {1'b0, BOOT, NOP, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_values: got req=%b addr=%h instr=%h pc=%h pc4=%h, expected req=0 addr=%h instr=%h pc=0 pc4=0",
                     bus.instr_req_o, bus.instr_addr_o, d_instr, d_pc, d_pc4, BOOT, NOP);
        end
        g0 = gnt_log.size();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.instr_req_o, bus.instr_addr_o} !== {1'b1, BOOT}) begin
            n_bad++;
            $display("FAIL reset_first_req: got req=%b addr=%h, expected req=1 addr=%h",
                     bus.instr_req_o, bus.instr_addr_o, BOOT);
        end
        repeat (3) @(posedge clk);
        n_cmp++;
        if (gnt_log.size() <= g0 || gnt_log[g0] !== BOOT) begin
            n_bad++;
            $display("FAIL reset_first_gnt: got %0d grants, expected first grant at %h", gnt_log.size() - g0, BOOT);
        end
    endtask

    task automatic test_basic();
        logic [31:0] si[$], sp[$], s4[$];
        int bub[$];
        int nb, rv_at, d_at, exp_lat;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        nb = 0; rv_at = -1; d_at = -1;
        for (int c = 0; c < 60 && si.size() < 3; c++) begin
            @(posedge clk); #1;
            if (bus.instr_rvalid_i && rv_at < 0) rv_at = c;
            if (d_instr != NOP) begin
                if (d_at < 0) d_at = c;
                si.push_back(d_instr); sp.push_back(d_pc); s4.push_back(d_pc4);
                bub.push_back(nb); nb = 0;
            end else begin
                nb++;
            end
        end
        n_cmp++;
        if (si.size() != 3) begin
            n_bad++;
            $display("FAIL basic_timeout: got %0d instructions, expected 3", si.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if ({si[k], sp[k], s4[k]} !== {word_at(32'(4 * k)), 32'(4 * k), 32'(4 * k + 4)}) begin
                    n_bad++;
                    $display("FAIL basic_word%0d: got %h/%h/%h, expected %h/%h/%h", k, si[k], sp[k], s4[k],
                             word_at(32'(4 * k)), 32'(4 * k), 32'(4 * k + 4));
                end
            end
            n_cmp++;
            if (bub[1] < 1 || bub[2] < 1) begin
                n_bad++;
                $display("FAIL basic_bubbles: got %0d and %0d NOPs between words, expected at least 1", bub[1], bub[2]);
            end
`ifdef IF_BYPASS_EN
            exp_lat = 0;
`else
            exp_lat = 1;
`endif
            n_cmp++;
            if (d_at - rv_at != exp_lat) begin
                n_bad++;
                $display("FAIL basic_latency: got %0d, expected %0d extra cycles", d_at - rv_at, exp_lat);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] hi, hp, h4, i, p, p4;
        do_reset();
        next_decoded(ok, hi, hp, h4);
        stall = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({d_instr, d_pc, d_pc4} !== {hi, hp, h4}) begin
                n_bad++;
                $display("FAIL stall_hold: got %h/%h/%h, expected %h/%h/%h", d_instr, d_pc, d_pc4, hi, hp, h4);
            end
        end
        n_cmp++;
        if (bus.instr_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_full_req: got req=%b, expected 0", bus.instr_req_o);
        end
        stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            next_decoded(ok, i, p, p4);
            n_cmp++;
            if (!ok || {i, p, p4} !== {word_at(hp + 32'(4 * k)), hp + 32'(4 * k), hp + 32'(4 * k + 4)}) begin
                n_bad++;
                $display("FAIL stall_order%0d: got %h/%h (ok=%b), expected %h/%h", k, i, p, ok,
                         word_at(hp + 32'(4 * k)), hp + 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit ok, got;
        int g0;
        logic [31:0] i, p, p4;
        do_reset();
        lat_min = 2; lat_max = 2; got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.instr_gnt_i && gnt_log.size() >= 2) got = 1'b1;
        end
        @(posedge clk); #1;
        brj = 1'b1; brj_pc = 32'h0000_0100;
        @(posedge clk); #1;
        brj = 1'b0;
        g0 = gnt_log.size();
        n_cmp++;
        if (!got || d_instr !== NOP) begin
            n_bad++;
            $display("FAIL redir_nop: got %h (found=%b), expected %h", d_instr, got, NOP);
        end
        next_decoded(ok, i, p, p4);
        n_cmp++;
        if (gnt_log.size() <= g0 || gnt_log[g0] !== 32'h100) begin
            n_bad++;
            $display("FAIL redir_addr: got %0d new grants, expected first at 00000100", gnt_log.size() - g0);
        end
        n_cmp++;
        if (!ok || {i, p} !== {word_at(32'h100), 32'h100}) begin
            n_bad++;
            $display("FAIL redir_first: got %h/%h, expected %h/00000100", i, p, word_at(32'h100));
        end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_brj_stall();
        bit ok;
        logic [31:0] hi, hp, h4, i, p, p4;
        do_reset();
        next_decoded(ok, hi, hp, h4);
        stall = 1'b1; brj = 1'b1; brj_pc = 32'h0000_0200;
        @(posedge clk); #1;
        stall = 1'b0; brj = 1'b0;
        n_cmp++;
        if ({d_instr, d_pc, d_pc4} !== {hi, hp, h4}) begin
            n_bad++;
            $display("FAIL brjstall_hold: got %h/%h/%h, expected %h/%h/%h", d_instr, d_pc, d_pc4, hi, hp, h4);
        end
        for (int k = 1; k <= 3; k++) begin
            next_decoded(ok, i, p, p4);
            n_cmp++;
            if (!ok || p !== hp + 32'(4 * k)) begin
                n_bad++;
                $display("FAIL brjstall_seq%0d: got pc %h, expected %h", k, p, hp + 32'(4 * k));
            end
        end
    endtask

    task automatic test_align_wrap();
        bit ok;
        int g0;
        logic [31:0] i, p, p4;
        do_reset();
        next_decoded(ok, i, p, p4);
        brj = 1'b1; brj_pc = 32'h0000_0103;
        @(posedge clk); #1;
        brj = 1'b0;
        g0 = gnt_log.size();
        next_decoded(ok, i, p, p4);
        n_cmp++;
        if (gnt_log.size() <= g0 || gnt_log[g0] !== 32'h100 || p !== 32'h100) begin
            n_bad++;
            $display("FAIL align: got decoded pc %h, expected grant and pc 00000100", p);
        end
        brj = 1'b1; brj_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        brj = 1'b0;
        g0 = gnt_log.size();
        next_decoded(ok, i, p, p4);
        n_cmp++;
        if (!ok || {i, p, p4} !== {word_at(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0}) begin
            n_bad++;
            $display("FAIL wrap_top: got %h/%h/%h, expected %h/fffffffc/00000000", i, p, p4, word_at(32'hFFFF_FFFC));
        end
        next_decoded(ok, i, p, p4);
        n_cmp++;
        if (!ok || {i, p, p4} !== {word_at(32'h0), 32'h0, 32'h4}) begin
            n_bad++;
            $display("FAIL wrap_zero: got %h/%h/%h, expected %h/00000000/00000004", i, p, p4, word_at(32'h0));
        end
        n_cmp++;
        if (gnt_log.size() < g0 + 2 || gnt_log[g0 + 1] !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_addr: got %0d grants after redirect, expected second at 00000000", gnt_log.size() - g0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, got;
        int g0;
        logic [31:0] i, p, p4;
        do_reset();
        lat_min = 6; lat_max = 6; got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.instr_gnt_i && gnt_log.size() >= 2) got = 1'b1;
        end
        lat_min = 1; lat_max = 1;
        @(posedge clk); #1;
        keep_pend = 1'b1; stale_seen = 1'b0;
        rst_n = 1'b0; #1;
        n_cmp++;
        if (!got || {bus.instr_req_o, bus.instr_addr_o, d_instr, d_pc, d_pc4} !== {1'b0, BOOT, NOP, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL midreset_values: got req=%b addr=%h instr=%h pc=%h (found=%b), expected reset values",
                     bus.instr_req_o, bus.instr_addr_o, d_instr, d_pc, got);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        g0 = gnt_log.size();
        next_decoded(ok, i, p, p4);
        n_cmp++;
        if (stale_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_stale: got stale_seen=%b, expected 1", stale_seen);
        end
        n_cmp++;
        if (gnt_log.size() <= g0 || gnt_log[g0] !== BOOT) begin
            n_bad++;
            $display("FAIL midreset_addr: got %0d grants, expected first at %h", gnt_log.size() - g0, BOOT);
        end
        n_cmp++;
        if (!ok || {i, p, p4} !== {word_at(BOOT), BOOT, BOOT + 32'd4}) begin
            n_bad++;
            $display("FAIL midreset_first: got %h/%h/%h, expected %h/%h/%h", i, p, p4, word_at(BOOT), BOOT, BOOT + 32'd4);
        end
        keep_pend = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, hi, hp, h4, ap, t;
        bit s, b, rp, gs;
        int ndec;
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        do_reset();
        exp_pc = BOOT; ndec = 0;
        hi = d_instr; hp = d_pc; h4 = d_pc4; rp = bus.instr_req_o; ap = bus.instr_addr_o;
        for (int c = 0; c < 2500; c++) begin
            s = (int'($urandom_range(99)) < 20);
            b = (int'($urandom_range(99)) < 6);
            t = $urandom();
            stall = s; brj = b; brj_pc = t;
            @(posedge clk); #1;
            gs = bus.instr_gnt_i;
            n_cmp++;
            if (s) begin
                if ({d_instr, d_pc, d_pc4} !== {hi, hp, h4}) begin
                    n_bad++;
                    $display("FAIL rnd_stall c=%0d: got %h/%h/%h, expected %h/%h/%h", c, d_instr, d_pc, d_pc4, hi, hp, h4);
                end
            end else if (b) begin
                if (d_instr !== NOP) begin
                    n_bad++;
                    $display("FAIL rnd_redirect c=%0d: got %h, expected %h", c, d_instr, NOP);
                end
                exp_pc = {t[31:2], 2'b00};
            end else if (d_instr != NOP) begin
                if ({d_instr, d_pc, d_pc4} !== {word_at(exp_pc), exp_pc, exp_pc + 32'd4}) begin
                    n_bad++;
                    $display("FAIL rnd_decode c=%0d: got %h/%h/%h, expected %h/%h/%h", c, d_instr, d_pc, d_pc4,
                             word_at(exp_pc), exp_pc, exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                ndec++;
            end else if ({d_pc, d_pc4} !== {hp, h4}) begin
                n_bad++;
                $display("FAIL rnd_bubble c=%0d: got pc %h/%h, expected %h/%h", c, d_pc, d_pc4, hp, h4);
            end
            if (rp && !gs && !(b && !s) && bus.instr_req_o) begin
                n_cmp++;
                if (bus.instr_addr_o !== ap) begin
                    n_bad++;
                    $display("FAIL rnd_addr_stable c=%0d: got %h, expected %h", c, bus.instr_addr_o, ap);
                end
            end
            if (bus.instr_req_o) begin
                n_cmp++;
                if (bus.instr_addr_o[1:0] !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rnd_align c=%0d: got addr %h, expected word aligned", c, bus.instr_addr_o);
                end
            end
            hi = d_instr; hp = d_pc; h4 = d_pc4; rp = bus.instr_req_o; ap = bus.instr_addr_o;
        end
        stall = 1'b0; brj = 1'b0;
        n_cmp++;
        if (ndec < 100) begin
            n_bad++;
            $display("FAIL rnd_progress: got %0d decoded instructions, expected at least 100", ndec);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_brj_stall();
        test_align_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage, directly upstream of the decode stage. It owns the fetch PC and drives a request/grant/rvalid instruction-memory handshake. Fetched words are buffered in a small prefetch FIFO and presented to decode as instruction, PC and PC+4 registers. It honours decode's stall and branch/jump redirect, and injects NOP bubbles where needed.

Parameters:
BOOT_ADDR, 32'h0000_0000, fetch PC after reset
FIFO_DEPTH, 2, prefetch entries (power of 2, >=2)
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  clock
rst_n  input  1  async active-low reset
instr_req_o  output  1  memory request
instr_addr_o  output  32  request address, word aligned
instr_gnt_i  input  1  request accepted this cycle
instr_rvalid_i  input  1  read data valid (one per grant, in order, >=1 cycle after gnt)
instr_rdata_i  input  32  instruction word
stall_i  input  1  decode hazard stall; hold outputs
brj_i  input  1  branch/jump taken in decode
brj_pc_i  input  32  redirect target
d_instruction_o  output  32  instruction to decode
d_pc_o  output  32  PC of d_instruction_o
d_pc4_o  output  32  d_pc_o+4

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: instr_req_o=0, instr_addr_o=BOOT_ADDR, d_instruction_o=NOP_INSTR, d_pc_o=0, d_pc4_o=0, FIFO empty, FSM=REQ, discard=0, fetch_pc=BOOT_ADDR.
- FSM states:
  - REQ: instr_req_o=1 when FIFO count + outstanding < FIFO_DEPTH; instr_addr_o=fetch_pc.
    - instr_gnt_i & instr_req_o: fetch_pc+=4, go WAIT.
  - WAIT: instr_req_o=0.
    - instr_rvalid_i & !discard: push {pc, rdata}.
    - instr_rvalid_i (either case): clear discard, go REQ.
  - At most one outstanding request. A rvalid arriving in REQ is ignored (covers reset mid-transaction).
- Address rules:
  - instr_addr_o is stable while instr_req_o=1 and gnt=0, unless a redirect occurs.
  - fetch_pc wraps modulo 2^32.
  - The redirect target is forced word aligned: {brj_pc_i[31:2],2'b00}.
- Decode register update, in priority order:
  1. stall_i=1: hold d_* and the FIFO. brj_i is ignored while stall_i=1.
  2. brj_i=1:
     - Flush the FIFO; d_instruction_o<=NOP_INSTR; fetch_pc<=target.
     - In WAIT, or in REQ with gnt this cycle: set discard and go/stay WAIT.
     - In REQ without gnt: next instr_addr_o=target.
  3. FIFO non-empty: pop head into d_instruction_o, d_pc_o, d_pc4_o=d_pc_o+4.
  4. Otherwise: d_instruction_o<=NOP_INSTR; d_pc_o and d_pc4_o hold.
- Simultaneous push and pop are allowed. Push to a full FIFO cannot occur, because requests are gated by free space.
- Latency: rvalid at edge N gives d_instruction_o at N+1 with bypass, N+2 without (see Optional Feature).
- After reset release: req in the first cycle, address BOOT_ADDR.

Optional Feature:
IF_BYPASS_EN
- Defined: when the FIFO is empty, stall_i=0, brj_i=0 and a valid non-discarded rvalid arrives, the data loads directly into d_* and is not pushed. Fetch-to-decode latency is 1 cycle.
- Undefined: every response goes through the FIFO, giving 2-cycle latency. Otherwise identical.

Test Plan:
- Reset, memory gnt same cycle, rvalid next cycle, words A,B,C -> addresses 0,4,8 in order. d_instruction_o=A with d_pc_o=0, d_pc4_o=4; then B at 4/8; C at 8/12. A bubble NOP appears between them because of the single outstanding request.
- Hold stall_i=1 for 3 cycles while B is presented -> d_* keep B/4/8. The FIFO fills to FIFO_DEPTH and instr_req_o drops to 0. After release, B leaves first, then queued words in order with no loss.
- brj_i=1 with brj_pc_i=0x100 while in WAIT -> d_instruction_o=0x00000013 next cycle. The pending rvalid data is dropped. The next instr_addr_o is 0x100, and the first decoded PC after the redirect is 0x100.
- brj_i=1 and stall_i=1 in the same cycle with target 0x200 -> redirect ignored; d_* held and fetch_pc unchanged.
- brj_pc_i=0x103 -> instr_addr_o=0x100. fetch_pc at 0xFFFF_FFFC granted -> next address 0x0000_0000.
- rst_n asserted while in WAIT, rvalid arrives after release -> response ignored. Outputs hold reset values, and the first request goes to BOOT_ADDR.
